wb_stage_regfile: RTL and testbench
===================================

Name: wb_stage_regfile

Overview:
Parametrised write-back stage with an integrated register file. It sits after the memory stage and accepts one instruction per cycle through a valid/ready handshake. Loads are handled by a request/response FSM, with byte-lane alignment and sign/zero extension. The block writes the destination register on the rising clock edge, provides bypassed read ports to decode, and emits a registered retire trace with a retire counter.

Parameters:
XLEN, 32, datapath width; only 32 or 64 are legal.
NUM_REGS, 32, number of architectural registers; must be a power of 2 and ≤32. x0 is hard-wired to zero.
NUM_RD_PORTS, 2, number of combinational read ports toward decode.
CNT_W, 64, width of the retire counter.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous reset, active-high.
valid_i  in  1  an instruction is presented by the memory stage.
ready_o  out  1  the stage can accept an instruction this cycle.
pc_i  in  XLEN  PC of the presented instruction.
instr_i  in  32  the presented instruction word.
rf_we_i  in  1  the instruction writes rd.
alu_out_i  in  XLEN  ALU result; for loads, the effective address.
load_req_o  out  1  one-cycle load request pulse.
load_addr_o  out  XLEN  load address, aligned down to XLEN/8 bytes.
load_rvalid_i  in  1  load response valid.
load_rdata_i  in  XLEN  load response data, full aligned word.
rs_addr_i  in  NUM_RD_PORTS x 5  read addresses.
rs_data_o  out  NUM_RD_PORTS x XLEN  read data, bypassed.
misalign_o  out  1  one-cycle pulse when a misaligned load is dropped.
retire_valid_o  out  1  registered retire pulse.
retire_pc_o  out  XLEN  PC of the retired instruction.
retire_instr_o  out  32  instruction word of the retired instruction.
retire_count_o  out  CNT_W  total retired instructions.

Behaviour:
- Accept condition: valid_i && ready_o.
  - ready_o = 1 in IDLE; ready_o = 0 in WAIT_LOAD.
- Load definition: an accepted instruction is a load iff rf_we_i = 1 and opcode = 0000011.
- Non-load, rf_we_i = 1:
  - On the accepting edge, rd = instr_i[11:7] is written with alu_out_i.
  - JAL (1101111) and JALR (1100111) write pc_i + 4 instead; the sum wraps modulo 2^XLEN.
- rf_we_i = 0: retire only, no register write.
- rd = 0 or rd ≥ NUM_REGS: no write; the instruction still retires.
- FSM states: IDLE, WAIT_LOAD.
  - IDLE, accepted load: load_req_o = 1 combinationally in the same cycle; load_addr_o = alu_out_i with the low bits cleared. Latch funct3, rd, byte offset, pc and instr; go to WAIT_LOAD.
  - WAIT_LOAD, load_rvalid_i = 1: extract, write rd, retire, return to IDLE.
  - WAIT_LOAD, load_rvalid_i = 0: hold.
  - load_rvalid_i is ignored in IDLE. Minimum load latency is 1 cycle.
- Extraction: the lane is selected by offset = addr[log2(XLEN/8)-1:0].
  - LB/LBU take byte[offset]. LH/LHU take the halfword at offset. LW takes the word at offset.
  - Signed forms replicate the MSB of the selected field. LB uses bit 7 of the selected byte; LH uses bit 15 of the selected halfword.
  - When XLEN = 64: LWU (110) zero-extends a word; LD (011) takes the full doubleword.
- Misaligned load (offset not a multiple of the access size):
  - Detected at accept.
  - No request is issued, no write occurs, and the FSM stays in IDLE.
  - misalign_o pulses on the next cycle; the instruction still retires.
- Illegal funct3, including 011/110 when XLEN = 32: the request is issued and rd is written with 0 on response.
- Read ports:
  - rs_data_o[k] = 0 when rs_addr_i[k] = 0 or rs_addr_i[k] ≥ NUM_REGS.
  - If a write to the same rd occurs at the coming edge, rs_data_o[k] returns the write data (write-through bypass).
  - Otherwise rs_data_o[k] returns the stored value.
- Retire:
  - Every retirement sets retire_valid_o = 1 for exactly the next cycle, with the matching pc and instr.
  - retire_count_o increments by 1 on the same edge and wraps at 2^CNT_W.
  - Pc and instr hold their last value while retire_valid_o = 0.
- Reset (rst_i = 1 at an edge):
  - All registers, retire_* outputs, retire_count_o and misalign_o clear to 0. FSM goes to IDLE.
  - A pending load is abandoned; a late load_rvalid_i is ignored.
  - Reset overrides a simultaneous accept or response.
- While rst_i = 1, ready_o = 0 and load_req_o = 0.

Test Plan:
1. ADDI x5 result, alu_out_i = 0x0000_1234, rf_we_i = 1 → rs_data_o reads x5 = 0x1234 in the same cycle via bypass and after the edge from storage; retire_valid_o pulses 1 cycle later; retire_count_o = 1.
2. JAL at pc_i = 0xFFFF_FFFC with rd = x1 → x1 = 0x0000_0000 (wrap).
3. LB at address 0x103 with load_rdata_i = 0x80FF_0000 and a 3-cycle response delay → load_req_o pulses once with load_addr_o = 0x100; ready_o = 0 for 3 cycles; rd = 0xFFFF_FF80. LBU on the same data → 0x0000_0080.
4. LH at address 0x101 → no load_req_o; misalign_o pulses; rd unchanged; retire_count_o increments.
5. Load accepted, then rst_i asserted in WAIT_LOAD, then load_rvalid_i → no write; all registers 0; ready_o = 1 after reset deasserts; retire_count_o = 0.
6. Write to x0 with alu_out_i = 0xDEAD_BEEF, and rs_addr_i = 0 → rs_data_o = 0; x0 remains 0; the instruction retires.

Source files
------------

// File: rtl/wb_stage_regfile.sv
// Write-back stage with integrated register file, load request/response FSM,
// lane extraction, bypassed decode read ports and a registered retire trace.
module wb_stage_regfile #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int CNT_W        = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [XLEN-1:0]                pc_i,
    input  logic [31:0]                    instr_i,
    input  logic                           rf_we_i,
    input  logic [XLEN-1:0]                alu_out_i,
    output logic                           load_req_o,
    output logic [XLEN-1:0]                load_addr_o,
    input  logic                           load_rvalid_i,
    input  logic [XLEN-1:0]                load_rdata_i,
    input  logic [NUM_RD_PORTS*5-1:0]      rs_addr_i,
    output logic [NUM_RD_PORTS*XLEN-1:0]   rs_data_o,
    output logic                           misalign_o,
    output logic                           retire_valid_o,
    output logic [XLEN-1:0]                retire_pc_o,
    output logic [31:0]                    retire_instr_o,
    output logic [CNT_W-1:0]               retire_count_o
);

    localparam int         OFFW  = $clog2(XLEN / 8);
    localparam int         AW    = $clog2(NUM_REGS);
    localparam logic [5:0] NREGS = 6'(NUM_REGS);

    typedef enum logic {IDLE, WAIT_LOAD} state_e;

    state_e            state_q, state_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [4:0]        ld_rd_q, ld_rd_d;
    logic [OFFW-1:0]   ld_off_q, ld_off_d;
    logic [XLEN-1:0]   ld_pc_q, ld_pc_d;
    logic [31:0]       ld_instr_q, ld_instr_d;
    logic [XLEN-1:0]   regs_q [NUM_REGS];
    logic [XLEN-1:0]   regs_d [NUM_REGS];
    logic              ret_valid_q, ret_valid_d;
    logic [XLEN-1:0]   ret_pc_q, ret_pc_d;
    logic [31:0]       ret_instr_q, ret_instr_d;
    logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
    logic              misalign_q, misalign_d;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic [OFFW-1:0]   off;
    logic              accept, is_load, mis, resp;
    logic              we, we_ok;
    logic [4:0]        waddr;
    logic [XLEN-1:0]   wdata, ld_data, sh;

    assign opcode      = instr_i[6:0];
    assign funct3      = instr_i[14:12];
    assign rd          = instr_i[11:7];
    assign off         = alu_out_i[OFFW-1:0];
    assign ready_o     = (state_q == IDLE) && !rst_i;
    assign accept      = valid_i && ready_o;
    assign is_load     = rf_we_i && (opcode == 7'b0000011);
    assign load_req_o  = accept && is_load && !mis;
    assign load_addr_o = alu_out_i & ~(XLEN'(XLEN / 8 - 1));
    assign resp        = (state_q == WAIT_LOAD) && load_rvalid_i && !rst_i;

    // Illegal funct3 never counts as misaligned: it is requested and writes 0.
    always_comb begin
        mis = 1'b0;
        case (funct3)
            3'b001, 3'b101: mis = off[0];
            3'b010:         mis = |off[1:0];
            3'b110:         mis = (XLEN == 64) && (|off[1:0]);
            3'b011:         mis = (XLEN == 64) && (|off);
            default:        mis = 1'b0;
        endcase
    end

    assign sh = load_rdata_i >> {ld_off_q, 3'b000};

    always_comb begin
        ld_data = '0;
        case (ld_f3_q)
            3'b000:  ld_data = XLEN'($signed(sh[7:0]));
            3'b100:  ld_data = XLEN'(sh[7:0]);
            3'b001:  ld_data = XLEN'($signed(sh[15:0]));
            3'b101:  ld_data = XLEN'(sh[15:0]);
            3'b010:  ld_data = XLEN'($signed(sh[31:0]));
            3'b110:  ld_data = (XLEN == 64) ? XLEN'(sh[31:0]) : '0;
            3'b011:  ld_data = (XLEN == 64) ? sh : '0;
            default: ld_data = '0;
        endcase
    end

    always_comb begin
        we    = 1'b0;
        waddr = rd;
        wdata = alu_out_i;
        if (resp) begin
            we    = 1'b1;
            waddr = ld_rd_q;
            wdata = ld_data;
        end else if (accept && rf_we_i && !is_load) begin
            we = 1'b1;
            if (opcode == 7'b1101111 || opcode == 7'b1100111)
                wdata = pc_i + XLEN'(4);
        end
    end

    assign we_ok = we && (waddr != 5'd0) && ({1'b0, waddr} < NREGS);

    always_comb begin
        regs_d = regs_q;
        if (we_ok)
            regs_d[waddr[AW-1:0]] = wdata;
        regs_d[0] = '0;
    end

    for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
        logic [4:0] a;
        assign a = rs_addr_i[k*5 +: 5];
        assign rs_data_o[k*XLEN +: XLEN] =
            (a == 5'd0 || {1'b0, a} >= NREGS) ? '0 :
            (we_ok && waddr == a)             ? wdata :
                                                regs_q[a[AW-1:0]];
    end

    always_comb begin
        state_d     = state_q;
        ld_f3_d     = ld_f3_q;
        ld_rd_d     = ld_rd_q;
        ld_off_d    = ld_off_q;
        ld_pc_d     = ld_pc_q;
        ld_instr_d  = ld_instr_q;
        ret_valid_d = 1'b0;
        ret_pc_d    = ret_pc_q;
        ret_instr_d = ret_instr_q;
        ret_cnt_d   = ret_cnt_q;
        misalign_d  = accept && is_load && mis;
        if (resp) begin
            state_d     = IDLE;
            ret_valid_d = 1'b1;
            ret_pc_d    = ld_pc_q;
            ret_instr_d = ld_instr_q;
        end else if (load_req_o) begin
            state_d    = WAIT_LOAD;
            ld_f3_d    = funct3;
            ld_rd_d    = rd;
            ld_off_d   = off;
            ld_pc_d    = pc_i;
            ld_instr_d = instr_i;
        end else if (accept) begin
            ret_valid_d = 1'b1;
            ret_pc_d    = pc_i;
            ret_instr_d = instr_i;
        end
        if (ret_valid_d)
            ret_cnt_d = ret_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ld_f3_q     <= '0;
            ld_rd_q     <= '0;
            ld_off_q    <= '0;
            ld_pc_q     <= '0;
            ld_instr_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
            ret_valid_q <= 1'b0;
            ret_pc_q    <= '0;
            ret_instr_q <= '0;
            ret_cnt_q   <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_f3_q     <= ld_f3_d;
            ld_rd_q     <= ld_rd_d;
            ld_off_q    <= ld_off_d;
            ld_pc_q     <= ld_pc_d;
            ld_instr_q  <= ld_instr_d;
            regs_q      <= regs_d;
            ret_valid_q <= ret_valid_d;
            ret_pc_q    <= ret_pc_d;
            ret_instr_q <= ret_instr_d;
            ret_cnt_q   <= ret_cnt_d;
            misalign_q  <= misalign_d;
        end
    end

    assign misalign_o     = misalign_q;
    assign retire_valid_o = ret_valid_q;
    assign retire_pc_o    = ret_pc_q;
    assign retire_instr_o = ret_instr_q;
    assign retire_count_o = ret_cnt_q;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Bench for wb_stage_regfile: directed scenarios then random traffic,
// all checked against an instruction-level reference model.
module tb_wb_stage_regfile;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_ALUI = 7'b0010011;
    localparam logic [6:0] OP_ALU  = 7'b0110011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ST   = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst_i, valid_i, ready_o, rf_we_i;
    logic [31:0] pc_i, instr_i, alu_out_i;
    logic        load_req_o, load_rvalid_i;
    logic [31:0] load_addr_o, load_rdata_i;
    logic [9:0]  rs_addr_i;
    logic [63:0] rs_data_o;
    logic        misalign_o, retire_valid_o;
    logic [31:0] retire_pc_o, retire_instr_o;
    logic [63:0] retire_count_o;

    always #5 clk = ~clk;

    wb_stage_regfile dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .pc_i(pc_i), .instr_i(instr_i), .rf_we_i(rf_we_i),
        .alu_out_i(alu_out_i), .load_req_o(load_req_o),
        .load_addr_o(load_addr_o), .load_rvalid_i(load_rvalid_i),
        .load_rdata_i(load_rdata_i), .rs_addr_i(rs_addr_i),
        .rs_data_o(rs_data_o), .misalign_o(misalign_o),
        .retire_valid_o(retire_valid_o), .retire_pc_o(retire_pc_o),
        .retire_instr_o(retire_instr_o), .retire_count_o(retire_count_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: architectural state plus one outstanding load.
    logic [31:0] mregs [32];
    bit          pend;
    logic [2:0]  p_f3;
    logic [4:0]  p_rd;
    logic [31:0] p_addr, p_pc, p_instr;
    bit          e_rv, e_mis;
    logic [31:0] e_pc, e_instr;
    logic [63:0] e_cnt;
    logic [31:0] got_rs0;
    bit          got_req, got_ready;
    logic [31:0] got_addr;

    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3,
                                             input logic [31:0] addr,
                                             input logic [31:0] data);
        logic [31:0] w, b, h;
        w = data >> (8 * (addr % 4));
        b = w % 256;
        h = w % 65536;
        case (f3)
            3'd0: return (b >= 128) ? b - 32'd256 : b;
            3'd4: return b;
            3'd1: return (h >= 32768) ? h - 32'd65536 : h;
            3'd5: return h;
            3'd2: return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [2:0] f3,
                                       input logic [4:0] rd,
                                       input logic [6:0] op);
        logic [31:0] r;
        r = $urandom();
        return {r[31:15], f3, rd, op};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        pend = 0; e_rv = 0; e_mis = 0;
        e_pc = '0; e_instr = '0; e_cnt = '0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] ins);
        e_rv = 1; e_pc = pc; e_instr = ins; e_cnt = e_cnt + 1;
    endtask

    function automatic logic [31:0] rd_exp(input logic [4:0] a, input bit wr,
                                           input logic [4:0] wa,
                                           input logic [31:0] wd);
        if (a == 0) return '0;
        if (wr && wa == a) return wd;
        return mregs[a];
    endfunction

    task automatic step(input bit rst, input bit v, input logic [31:0] pc,
                        input logic [31:0] ins, input bit we,
                        input logic [31:0] alu, input bit rv,
                        input logic [31:0] rdat, input logic [4:0] a0,
                        input logic [4:0] a1);
        bit rdy, acc, isl, mis, req, wr, jmp;
        int sz;
        logic [4:0]  wa;
        logic [31:0] wd;
        check("retire_valid", {63'd0, retire_valid_o}, {63'd0, e_rv});
        check("retire_pc", {32'd0, retire_pc_o}, {32'd0, e_pc});
        check("retire_instr", {32'd0, retire_instr_o}, {32'd0, e_instr});
        check("retire_count", retire_count_o, e_cnt);
        check("misalign", {63'd0, misalign_o}, {63'd0, e_mis});
        rst_i = rst; valid_i = v; pc_i = pc; instr_i = ins; rf_we_i = we;
        alu_out_i = alu; load_rvalid_i = rv; load_rdata_i = rdat;
        rs_addr_i = {a1, a0};
        #1;
        rdy = !rst && !pend;
        acc = v && rdy;
        isl = we && ins[6:0] == OP_LOAD;
        sz  = acc_size(ins[14:12]);
        mis = isl && sz != 0 && (alu % sz) != 0;
        req = acc && isl && !mis;
        check("ready", {63'd0, ready_o}, {63'd0, rdy});
        check("load_req", {63'd0, load_req_o}, {63'd0, req});
        if (req)
            check("load_addr", {32'd0, load_addr_o}, {32'd0, alu - alu % 4});
        wr = 0; wa = '0; wd = '0;
        jmp = ins[6:0] == OP_JAL || ins[6:0] == OP_JALR;
        if (!rst && pend && rv) begin
            wr = 1; wa = p_rd; wd = load_val(p_f3, p_addr, rdat);
        end else if (acc && we && !isl) begin
            wr = 1; wa = ins[11:7]; wd = jmp ? pc + 32'd4 : alu;
        end
        check("rs0", {32'd0, rs_data_o[31:0]}, {32'd0, rd_exp(a0, wr, wa, wd)});
        check("rs1", {32'd0, rs_data_o[63:32]}, {32'd0, rd_exp(a1, wr, wa, wd)});
        got_rs0 = rs_data_o[31:0]; got_req = load_req_o;
        got_addr = load_addr_o; got_ready = ready_o;
        if (rst) begin
            model_reset();
        end else begin
            e_rv  = 0;
            e_mis = acc && mis;
            if (wr && wa != 0) mregs[wa] = wd;
            if (pend && rv) begin
                retire(p_pc, p_instr);
                pend = 0;
            end else if (req) begin
                pend = 1; p_f3 = ins[14:12]; p_rd = ins[11:7];
                p_addr = alu; p_pc = pc; p_instr = ins;
            end else if (acc) begin
                retire(pc, ins);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rv, input logic [31:0] rdat,
                        input logic [4:0] a0);
        step(0, 0, 32'h0, 32'h0, 0, 32'h0, rv, rdat, a0, 5'd0);
    endtask

    logic [31:0] r_ins, r_alu, r_pc;
    logic [6:0]  r_op;
    logic [4:0]  r_rd;
    int          kind;

    initial begin
        rst_i = 1; valid_i = 0; pc_i = '0; instr_i = '0; rf_we_i = 0;
        alu_out_i = '0; load_rvalid_i = 0; load_rdata_i = '0; rs_addr_i = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // ADDI x5: bypass in the accept cycle, storage afterwards
        step(0, 1, 32'h100, mk(3'd0, 5'd5, OP_ALUI), 1, 32'h1234, 0, 0,
             5'd5, 5'd0);
        check("tp1_bypass", {32'd0, got_rs0}, 64'h1234);
        check("tp1_rv", {63'd0, retire_valid_o}, 64'd1);
        check("tp1_cnt", retire_count_o, 64'd1);
        idle(0, 0, 5'd5);
        check("tp1_store", {32'd0, got_rs0}, 64'h1234);

        // JAL wraps pc + 4
        step(0, 1, 32'hFFFF_FFFC, mk(3'd0, 5'd1, OP_JAL), 1, 32'h55, 0, 0,
             5'd1, 5'd0);
        idle(0, 0, 5'd1);
        check("tp2_jal_wrap", {32'd0, got_rs0}, 64'h0);

        // LB at 0x103, response after three wait cycles
        step(0, 1, 32'h200, mk(3'd0, 5'd6, OP_LOAD), 1, 32'h103, 0, 0,
             5'd6, 5'd0);
        check("tp3_req", {63'd0, got_req}, 64'd1);
        check("tp3_addr", {32'd0, got_addr}, 64'h100);
        idle(0, 32'h80FF_0000, 5'd6);
        check("tp3_busy1", {63'd0, got_ready}, 64'd0);
        idle(0, 32'h80FF_0000, 5'd6);
        idle(1, 32'h80FF_0000, 5'd6);
        check("tp3_busy3", {63'd0, got_ready}, 64'd0);
        idle(0, 0, 5'd6);
        check("tp3_lb", {32'd0, got_rs0}, 64'hFFFF_FF80);
        step(0, 1, 32'h204, mk(3'd4, 5'd7, OP_LOAD), 1, 32'h103, 0, 0,
             5'd7, 5'd0);
        idle(1, 32'h80FF_0000, 5'd7);
        idle(0, 0, 5'd7);
        check("tp3_lbu", {32'd0, got_rs0}, 64'h80);

        // Misaligned LH: dropped, still retires
        step(0, 1, 32'h208, mk(3'd1, 5'd6, OP_LOAD), 1, 32'h101, 0, 0,
             5'd6, 5'd0);
        check("tp4_noreq", {63'd0, got_req}, 64'd0);
        check("tp4_mis", {63'd0, misalign_o}, 64'd1);
        idle(0, 0, 5'd6);
        check("tp4_keep", {32'd0, got_rs0}, 64'hFFFF_FF80);

        // Reset abandons a pending load; late response ignored
        step(0, 1, 32'h20C, mk(3'd2, 5'd8, OP_LOAD), 1, 32'h200, 0, 0,
             5'd8, 5'd0);
        step(1, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h1111_1111, 5'd8, 5'd0);
        idle(1, 32'h2222_2222, 5'd8);
        check("tp5_ready", {63'd0, got_ready}, 64'd1);
        check("tp5_nowrite", {32'd0, got_rs0}, 64'h0);
        check("tp5_cnt", retire_count_o, 64'd0);
        idle(0, 0, 5'd5);
        check("tp5_cleared", {32'd0, got_rs0}, 64'h0);

        // Write to x0 is discarded but retires
        step(0, 1, 32'h300, mk(3'd0, 5'd0, OP_ALU), 1, 32'hDEAD_BEEF, 0, 0,
             5'd0, 5'd0);
        check("tp6_x0_byp", {32'd0, got_rs0}, 64'h0);
        check("tp6_rv", {63'd0, retire_valid_o}, 64'd1);
        idle(0, 0, 5'd0);

        for (int i = 0; i < 3000; i++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1:    r_op = OP_ALUI;
                2, 3:    r_op = OP_ALU;
                4:       r_op = OP_JAL;
                5:       r_op = OP_JALR;
                9:       r_op = OP_ST;
                default: r_op = OP_LOAD;
            endcase
            r_rd  = 5'($urandom_range(0, 31));
            r_ins = mk(3'($urandom_range(0, 7)), r_rd, r_op);
            r_alu = $urandom();
            r_pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                                 : ($urandom() & ~32'h3);
            step($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
                 r_pc, r_ins,
                 (kind != 9) && ($urandom_range(0, 9) != 0), r_alu,
                 $urandom_range(0, 2) == 0, $urandom(),
                 $urandom_range(0, 1) ? r_rd : 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
